// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
// Shared TMDS definitions for the receive-side decoder (and usable by encoder
// benches): the four control tokens, the alignment FSM state type, a helper
// that recognises control tokens and a helper that decodes a data symbol.
// No ports (package).
// ---------------------------------------------------------------------------
package tmds_pkg;

    // Control tokens, written bit 9 down to bit 0.
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } tmds_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] code;
    } ctrl_token_t;

    // Undo the TMDS transition-minimising stage: q[9] flags inverted payload,
    // q[8] selects XOR (1) or XNOR (0) chaining.
    function automatic logic [7:0] tmds_decode_word(input logic [9:0] sym);
        logic [9:0] q;
        logic [7:0] d;
        q = sym;
        if (q[9]) begin
            q[7:0] = ~q[7:0];
        end
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic ctrl_token_t is_ctrl_token(input logic [9:0] sym);
        ctrl_token_t t;
        t.valid = 1'b1;
        t.code  = 2'b00;
        case (sym)
            CTRL_00: t.code = 2'b00;
            CTRL_01: t.code = 2'b01;
            CTRL_10: t.code = 2'b10;
            CTRL_11: t.code = 2'b11;
            default: t.valid = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_bitslip.sv
// ---------------------------------------------------------------------------
// tmds_bitslip
// Holds the previous deserialized word and selects a 10-bit symbol out of the
// 20-bit window {current, previous} starting at the requested bit offset.
// Offset 0 returns the previous word unchanged.
//
// Ports:
//   clk          in   pixel clock
//   reset_n_i    in   synchronous active-low reset (clears previous word)
//   tmds_word_i  in   raw 10-bit word, bit 0 received first
//   offset_i     in   bit offset 0..9
//   sym_o        out  aligned 10-bit symbol (combinational)
// ---------------------------------------------------------------------------
module tmds_bitslip
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [9:0] tmds_word_i,
    input  logic [3:0] offset_i,
    output logic [9:0] sym_o
);

    logic [9:0]  prev_word_q;
    logic [9:0]  prev_word_d;
    logic [19:0] window;

    assign prev_word_d = tmds_word_i;
    // Older word sits in the low half because bit 0 arrives first.
    assign window      = {tmds_word_i, prev_word_q};

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            prev_word_q <= '0;
        end else begin
            prev_word_q <= prev_word_d;
        end
    end

    // Constant slices per offset; out-of-range offsets fall back to offset 0.
    always_comb begin
        sym_o = prev_word_q;
        for (int k = 0; k < 10; k++) begin
            if (offset_i == 4'(k)) begin
                sym_o = window[k +: 10];
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// ---------------------------------------------------------------------------
// tmds_decoder
// One TMDS channel receiver: bit-slip search for symbol alignment on runs of
// identical control tokens, lock supervision, and registered decode of the
// aligned symbol to pixel data or control bits.
//
// Ports:
//   clk          in   pixel clock, rising edge
//   reset_n_i    in   synchronous active-low reset
//   tmds_word_i  in   raw 10-bit deserialized word, bit 0 first
//   data_o       out  decoded pixel byte (0 outside locked data periods)
//   c0_o, c1_o   out  control bits (hsync/vsync on channel 0)
//   de_o         out  1 = data symbol, 0 = control symbol
//   locked_o     out  symbol alignment established
//   offset_o     out  current bit-slip offset 0..9
// ---------------------------------------------------------------------------
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOCK_TIMEOUT  = 4096
) (
    input  logic       clk,
    input  logic       reset_n_i,
    input  logic [9:0] tmds_word_i,
    output logic [7:0] data_o,
    output logic       c0_o,
    output logic       c1_o,
    output logic       de_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
    localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_TOKENS);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
    localparam logic [IDLE_W-1:0] IDLE_DROP = IDLE_W'(LOCK_TIMEOUT);

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off == 4'd9) ? 4'd0 : off + 4'd1;
    endfunction

    tmds_state_e       state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d, run_next;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_next;
    logic [1:0]        last_code_q, last_code_d;

    logic [7:0]        data_q, data_d;
    logic              c0_q, c0_d;
    logic              c1_q, c1_d;
    logic              de_q, de_d;
    logic              locked_q, locked_d;

    logic [9:0]        sym;
    ctrl_token_t       tok;

    tmds_bitslip u_bitslip (
        .clk         (clk),
        .reset_n_i   (reset_n_i),
        .tmds_word_i (tmds_word_i),
        .offset_i    (offset_q),
        .sym_o       (sym)
    );

    assign tok = is_ctrl_token(sym);

    // Output decode: reflects the FSM state before this edge's update, so
    // locked_o follows the state change by one cycle.
    always_comb begin
        data_d   = '0;
        de_d     = 1'b0;
        c0_d     = c0_q;
        c1_d     = c1_q;
        locked_d = (state_q == LOCKED);
        if (state_q == LOCKED) begin
            if (tok.valid) begin
                {c1_d, c0_d} = tok.code;
            end else begin
                de_d   = 1'b1;
                data_d = tmds_decode_word(sym);
            end
        end else begin
            c0_d = 1'b0;
            c1_d = 1'b0;
        end
    end

    // Alignment FSM and its counters.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        run_cnt_d   = run_cnt_q;
        win_cnt_d   = win_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        last_code_d = last_code_q;
        run_next    = '0;
        idle_next   = '0;

        case (state_q)
            SEARCH: begin
                if (tok.valid) begin
                    // A run only continues on the same token value.
                    if ((run_cnt_q != '0) && (tok.code == last_code_q)) begin
                        run_next = (run_cnt_q == '1) ? run_cnt_q
                                                     : run_cnt_q + RUN_W'(1);
                    end else begin
                        run_next = RUN_W'(1);
                    end
                    last_code_d = tok.code;
                end

                // Lock takes priority over a coincident window expiry.
                if (run_next == RUN_LOCK) begin
                    state_d    = LOCKED;
                    run_cnt_d  = '0;
                    win_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    offset_d  = next_offset(offset_q);
                    win_cnt_d = '0;
                    run_cnt_d = '0;
                end else begin
                    win_cnt_d = (win_cnt_q == '1) ? win_cnt_q
                                                  : win_cnt_q + WIN_W'(1);
                    run_cnt_d = run_next;
                end
            end

            LOCKED: begin
                if (tok.valid) begin
                    idle_next = '0;
                end else begin
                    idle_next = (idle_cnt_q == '1) ? idle_cnt_q
                                                   : idle_cnt_q + IDLE_W'(1);
                end

                if (idle_next == IDLE_DROP) begin
                    state_d    = SEARCH;
                    offset_d   = next_offset(offset_q);
                    idle_cnt_d = '0;
                    run_cnt_d  = '0;
                    win_cnt_d  = '0;
                end else begin
                    idle_cnt_d = idle_next;
                end
            end

            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q     <= SEARCH;
            offset_q    <= '0;
            run_cnt_q   <= '0;
            win_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            last_code_q <= '0;
            data_q      <= '0;
            c0_q        <= 1'b0;
            c1_q        <= 1'b0;
            de_q        <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            run_cnt_q   <= run_cnt_d;
            win_cnt_q   <= win_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_code_q <= last_code_d;
            data_q      <= data_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            de_q        <= de_d;
            locked_q    <= locked_d;
        end
    end

    assign data_o   = data_q;
    assign c0_o     = c0_q;
    assign c1_o     = c1_q;
    assign de_o     = de_q;
    assign locked_o = locked_q;
    assign offset_o = offset_q;

endmodule
